// File: rtl/mycpu_pkg.sv
// Shared CPU-side definitions: default bus widths and the SRAM access owner encoding.
package mycpu_pkg;

  localparam int MYCPU_ADDR_W = 32;
  localparam int MYCPU_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_INST    = 2'd1,
    OWN_DATA_RD = 2'd2,
    OWN_DATA_WR = 2'd3
  } owner_e;

endpackage

// File: rtl/unified_sram_arbiter.sv
// Arbitrates one single-port SRAM between fetch and data ports; data wins contention
// unless fetch has been held off STARVE_MAX cycles. Read data is steered by the owner register.
module unified_sram_arbiter
  import mycpu_pkg::*;
#(
  parameter int ADDR_W     = MYCPU_ADDR_W,
  parameter int DATA_W     = MYCPU_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  owner_e           r_owner;
  logic [CNT_W-1:0] r_starve_cnt;

  logic   w_fetch_pri;
  logic   w_grant_inst;
  logic   w_grant_data;
  owner_e w_owner_nxt;

  // resetn gates the grant so every output drops as soon as reset asserts.
  assign w_fetch_pri  = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign w_grant_inst = resetn & inst_req & (~data_req | w_fetch_pri);
  assign w_grant_data = resetn & data_req & ~w_grant_inst;

  always_comb begin
    inst_addr_ok = w_grant_inst;
    data_addr_ok = w_grant_data;
    sram_en      = w_grant_inst | w_grant_data;
    sram_we      = '0;
    sram_addr    = '0;
    sram_wdata   = '0;
    w_owner_nxt  = OWN_NONE;
    if (w_grant_inst) begin
      sram_addr   = inst_addr;
      w_owner_nxt = OWN_INST;
    end else if (w_grant_data) begin
      sram_addr   = data_addr;
      sram_wdata  = data_wdata;
      if (data_wr) begin
        sram_we     = data_wstrb;
        w_owner_nxt = OWN_DATA_WR;
      end else begin
        w_owner_nxt = OWN_DATA_RD;
      end
    end
  end

  always_comb begin
    inst_data_ok = (r_owner == OWN_INST);
    data_data_ok = (r_owner == OWN_DATA_RD) || (r_owner == OWN_DATA_WR);
    inst_rdata   = (r_owner == OWN_INST)    ? sram_rdata : '0;
    data_rdata   = (r_owner == OWN_DATA_RD) ? sram_rdata : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner      <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      if (w_grant_inst) begin
        r_starve_cnt <= '0;
      end else if (inst_req && !w_fetch_pri) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/unified_sram_arbiter.md
# unified_sram_arbiter

Shares one synchronous single-port unified SRAM between the CPU's instruction-fetch port and data-access port, so the core can run from a single memory instead of separate inst/data SRAMs. Each port uses a req/addr_ok/data_ok handshake. Data accesses win contention by default, and a starvation guard bounds how long fetch can be held off. The arbiter tracks which port owns the in-flight access and routes the one-cycle-later SRAM read data back to that port.

## Interface
- ADDR_W, 32, address width on both ports and the SRAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets priority; must be ≥1.
- clk  in  1  clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- inst_req  in  1  fetch request; held until inst_addr_ok.
- inst_addr  in  ADDR_W  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data valid this cycle.
- inst_rdata  out  DATA_W  fetch data; 0 when inst_data_ok=0.
- data_req  in  1  data request; held until data_addr_ok.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  DATA_W/8  byte enables, used only for writes.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  DATA_W  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data access complete; read data valid.
- data_rdata  out  DATA_W  read data; 0 when data_data_ok=0 or the access was a write.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_en.

## Operation
- At most one grant per cycle. The grant is combinational from the current request signals and registered arbiter state.
- **Contention, data wins:** if both ports request and starve_cnt < STARVE_MAX, data is granted.
- **Contention, fetch wins:** if both ports request and starve_cnt == STARVE_MAX, fetch is granted.
- **Single requester:** a lone request is always granted.
- **Grant effects:**
  - The granted port's addr_ok = 1.
  - sram_en = 1.
  - sram_addr and sram_wdata come from the granted port.
  - sram_we = data_wstrb if a data write is granted, else 0.
- **Idle cycle:** sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.
- **Owner register** (NONE / INST / DATA_RD / DATA_WR) is loaded with the grant type each cycle. NONE is loaded when there is no grant.
- **Response cycle,** driven by the owner register:
  - INST: inst_data_ok = 1, inst_rdata = sram_rdata.
  - DATA_RD: data_data_ok = 1, data_rdata = sram_rdata.
  - DATA_WR: data_data_ok = 1, data_rdata = 0.
  - NONE: both data_ok outputs = 0.
- **Starvation counter starve_cnt:**
  - Increments, saturating at STARVE_MAX, on each cycle where inst_req=1 and fetch is not granted.
  - Clears to 0 when fetch is granted.
  - Holds when inst_req=0.
- Requesters never backpressure a response; data_ok is a single-cycle pulse.
- A request and a response on the same port in the same cycle is legal (back-to-back pipelining): the new access's response follows one cycle later.

## Timing
- Address phase has 0-cycle latency: addr_ok is in the same cycle as req when granted.
- data_ok arrives exactly 1 cycle after addr_ok, for reads and writes alike.
- Throughput: 1 access per cycle across both ports.
- Worst-case fetch wait under continuous data traffic is STARVE_MAX cycles. Fetch is then granted in cycle STARVE_MAX+1.
- **Reset (async assert):**
  - owner = NONE, starve_cnt = 0.
  - Every output is 0: both addr_ok, both data_ok, both rdata, sram_en, sram_we, sram_addr, sram_wdata.
- **Reset mid-operation:** an in-flight response is dropped (no data_ok), and requesters restart after deassertion.
- **Reset deassertion** is synchronized externally. The first grant is possible in the first cycle with resetn=1.
- **Write then read to the same address in consecutive cycles:** the read returns the new data. This relies on SRAM write-first ordering across cycles; the arbiter adds no forwarding.

## Structure
- Shared package (mycpu_pkg): owner enum (OWN_NONE, OWN_INST, OWN_DATA_RD, OWN_DATA_WR) and default ADDR_W/DATA_W constants.
- starve_cnt width: $clog2(STARVE_MAX+1).
- Single flat module with grant logic, owner register and starvation counter. No sub-module; the counter is too small to justify one.

## Test plan
- **Fetch only:** inst_req held for 3 cycles at addresses 0x1c000000/04/08, SRAM returns 0xA0/0xA1/0xA2.
  - Required: inst_addr_ok = 1 in each of the 3 cycles.
  - Required: inst_data_ok one cycle after each grant, with those values in order.
- **Contention:** both ports request in cycle 0, data_wr=0 at 0x100.
  - Required in cycle 0: data_addr_ok = 1, inst_addr_ok = 0.
  - Required in cycle 1: data_data_ok = 1, rdata = SRAM word; fetch is granted.
- **Starvation:** data_req continuous, inst_req continuous, STARVE_MAX=4.
  - Required: data granted in cycles 0–3, fetch granted in cycle 4, starve_cnt back to 0.
- **Byte write:** data_wr=1, wstrb=4'b0100, wdata=0x00AB0000, addr=0x200.
  - Required: sram_we = 4'b0100, data_data_ok next cycle with data_rdata = 0.
  - Required: a following read of 0x200 shows byte 2 = 0xAB.
- **Async reset mid-access:** resetn drops between a fetch grant and its response.
  - Required: all outputs 0 immediately, no inst_data_ok, owner = NONE.
  - Required: after release, a fresh request is granted.
